// File: rtl/cv1k_eeprom_pkg.sv
// Shared definitions for the CV1K serial EEPROM responder:
// Microwire opcodes, extended sub-codes, the FSM state encoding
// and the kinds of pending program operation.
package cv1k_eeprom_pkg;

    // Two-bit opcode following the start bit
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Extended commands, carried in the top two address bits of OP_EXT
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_READ_OUT,
        ST_WRITE_DATA,
        ST_WAIT_CE_LOW,
        ST_PROGRAM
    } state_t;

    // Program operation armed by a fully received write-type command
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WRITE,
        CMD_ERASE,
        CMD_ERAL,
        CMD_WRAL
    } cmd_t;

endpackage

// File: rtl/cv1k_serial_sync.sv
// Oversampling front end for the 3-wire serial link: two-flop
// synchronisers on ce, clk and di, plus single-cycle pulses for a
// serial-clock rising edge and a chip-enable falling edge.
module cv1k_serial_sync (
    input  logic clock,
    input  logic reset,
    input  logic ser_ce,
    input  logic ser_clk,
    input  logic ser_di,
    output logic ce_s,
    output logic di_s,
    output logic clk_rise,
    output logic ce_fall
);

    logic [1:0] ce_ff;
    logic [1:0] clk_ff;
    logic [1:0] di_ff;
    logic       clk_d;
    logic       ce_d;

    // Synchronise the pins and keep one extra stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_ff  <= '0;
            clk_ff <= '0;
            di_ff  <= '0;
            clk_d  <= 1'b0;
            ce_d   <= 1'b0;
        end else begin
            ce_ff  <= {ce_ff[0], ser_ce};
            clk_ff <= {clk_ff[0], ser_clk};
            di_ff  <= {di_ff[0], ser_di};
            clk_d  <= clk_ff[1];
            ce_d   <= ce_ff[1];
        end
    end

    assign ce_s     = ce_ff[1];
    assign di_s     = di_ff[1];
    assign clk_rise = clk_ff[1] & ~clk_d;
    assign ce_fall  = ce_d & ~ce_ff[1];

endmodule

// File: rtl/cv1k_serial_eeprom.sv
// 93C46-style Microwire EEPROM responder (64 x 16) for the CV1K CPLD
// serial link, oversampled on the system clock.
// Build option: define CV1K_EEPROM_SEQREAD_EN to let a READ keep
// streaming successive words while ce stays high.
//
// state          | meaning
// ---------------+-----------------------------------------------
// ST_IDLE        | waiting for a start bit (1) with ce high
// ST_OPCODE      | shifting in the 2-bit opcode
// ST_ADDR        | shifting in the word address, then dispatch
// ST_READ_OUT    | shifting the addressed word out on ser_do
// ST_WRITE_DATA  | shifting in the data word of WRITE / WRAL
// ST_WAIT_CE_LOW | command complete, waiting for ce to fall
// ST_PROGRAM     | busy programming, serial input ignored
module cv1k_serial_eeprom
    import cv1k_eeprom_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int WRITE_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic ser_ce,
    input  logic ser_clk,
    input  logic ser_di,
    output logic ser_do,
    output logic busy
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam int PCNT_W = $clog2(WRITE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // Power-up contents of an erased part; the array itself has no reset
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '1};

    logic              ce_s;
    logic              di_s;
    logic              clk_rise;
    logic              ce_fall;
    logic              sample;

    state_t            state;
    cmd_t              cmd;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BCNT_W-1:0] bits_left;
    logic              wen;
    logic [PCNT_W-1:0] prog_cnt;
    logic              sweep_on;
    logic [ADDR_W-1:0] sweep_addr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    cv1k_serial_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .ser_ce   (ser_ce),
        .ser_clk  (ser_clk),
        .ser_di   (ser_di),
        .ce_s     (ce_s),
        .di_s     (di_s),
        .clk_rise (clk_rise),
        .ce_fall  (ce_fall)
    );

    assign sample   = clk_rise & ce_s;
    assign addr_nxt = {addr[ADDR_W-2:0], di_s};

`ifdef CV1K_EEPROM_SEQREAD_EN
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] word_inc;
    assign addr_inc = addr + 1'b1;
    assign word_inc = mem[addr_inc];
`endif

    // Command decoder, program timer and registered serial output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cmd        <= CMD_NONE;
            opcode     <= '0;
            addr       <= '0;
            shreg      <= '0;
            bits_left  <= '0;
            wen        <= 1'b0;
            busy       <= 1'b0;
            ser_do     <= 1'b1;
            prog_cnt   <= '0;
            sweep_on   <= 1'b0;
            sweep_addr <= '0;
        end else if (ce_fall && state != ST_PROGRAM) begin
            ser_do <= 1'b1;
            if (state == ST_WAIT_CE_LOW && cmd != CMD_NONE && wen) begin
                state      <= ST_PROGRAM;
                busy       <= 1'b1;
                prog_cnt   <= PCNT_W'(WRITE_CYCLES - 1);
                sweep_on   <= (cmd == CMD_ERAL) || (cmd == CMD_WRAL);
                sweep_addr <= '0;
            end else begin
                state <= ST_IDLE;
                cmd   <= CMD_NONE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    ser_do <= 1'b1;
                    if (sample && di_s) begin
                        state     <= ST_OPCODE;
                        cmd       <= CMD_NONE;
                        bits_left <= BCNT_W'(1);
                    end
                end
                ST_OPCODE: begin
                    if (sample) begin
                        opcode <= {opcode[0], di_s};
                        if (bits_left == '0) begin
                            state     <= ST_ADDR;
                            bits_left <= BCNT_W'(ADDR_W - 1);
                        end else begin
                            bits_left <= bits_left - 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sample) begin
                        addr <= addr_nxt;
                        if (bits_left != '0) begin
                            bits_left <= bits_left - 1'b1;
                        end else begin
                            case (opcode)
                                OP_READ: begin
                                    state     <= ST_READ_OUT;
                                    ser_do    <= 1'b0;
                                    shreg     <= mem[addr_nxt];
                                    bits_left <= BCNT_W'(DATA_W);
                                end
                                OP_WRITE: begin
                                    state     <= ST_WRITE_DATA;
                                    bits_left <= BCNT_W'(DATA_W - 1);
                                end
                                OP_ERASE: begin
                                    state <= ST_WAIT_CE_LOW;
                                    cmd   <= CMD_ERASE;
                                end
                                default: begin
                                    case (addr_nxt[ADDR_W-1 -: 2])
                                        EXT_EWEN: begin
                                            wen   <= 1'b1;
                                            state <= ST_WAIT_CE_LOW;
                                        end
                                        EXT_EWDS: begin
                                            wen   <= 1'b0;
                                            state <= ST_WAIT_CE_LOW;
                                        end
                                        EXT_ERAL: begin
                                            cmd   <= CMD_ERAL;
                                            state <= ST_WAIT_CE_LOW;
                                        end
                                        default: begin
                                            state     <= ST_WRITE_DATA;
                                            bits_left <= BCNT_W'(DATA_W - 1);
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                ST_READ_OUT: begin
                    if (sample) begin
                        if (bits_left != '0) begin
                            ser_do    <= shreg[DATA_W-1];
                            shreg     <= {shreg[DATA_W-2:0], 1'b0};
                            bits_left <= bits_left - 1'b1;
                        end else begin
`ifdef CV1K_EEPROM_SEQREAD_EN
                            addr      <= addr_inc;
                            ser_do    <= word_inc[DATA_W-1];
                            shreg     <= {word_inc[DATA_W-2:0], 1'b0};
                            bits_left <= BCNT_W'(DATA_W - 1);
`else
                            ser_do <= 1'b1;
                            state  <= ST_WAIT_CE_LOW;
`endif
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (sample) begin
                        shreg <= {shreg[DATA_W-2:0], di_s};
                        if (bits_left == '0) begin
                            state <= ST_WAIT_CE_LOW;
                            cmd   <= (opcode == OP_WRITE) ? CMD_WRITE : CMD_WRAL;
                        end else begin
                            bits_left <= bits_left - 1'b1;
                        end
                    end
                end
                ST_WAIT_CE_LOW: begin
                    ser_do <= 1'b1;
                end
                ST_PROGRAM: begin
                    ser_do <= ~ce_s;
                    if (sweep_on) begin
                        sweep_addr <= sweep_addr + 1'b1;
                        if (sweep_addr == ADDR_LAST) begin
                            sweep_on <= 1'b0;
                        end
                    end
                    if (prog_cnt == '0) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        ser_do <= 1'b1;
                        cmd    <= CMD_NONE;
                    end else begin
                        prog_cnt <= prog_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-word programs commit on the last busy cycle so an aborted
    // program leaves the word untouched; bulk programs sweep from cycle one
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = '1;
        if (state == ST_PROGRAM) begin
            if (sweep_on) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_addr;
            end else if (prog_cnt == '0 && (cmd == CMD_WRITE || cmd == CMD_ERASE)) begin
                mem_we = 1'b1;
            end
            if (cmd == CMD_WRITE || cmd == CMD_WRAL) begin
                mem_wdata = shreg;
            end
        end
    end

    // Storage array write port
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
